// File: rtl/maxp_mem.sv
`default_nettype none
// ============================================================================
// Module   : maxp_mem
// Purpose  : 1R1W pixel scratchpad for maxp with range check and pass counters
// Revision : 1.0
// ============================================================================
module maxp_mem #(
  parameter int SIZE_1           = 11,
  parameter int SIZE_ADDRESS_PIX = 13,
  parameter int DEPTH            = 4096
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        re,
  input  logic [SIZE_ADDRESS_PIX-1:0] read_addressp,
  output logic [SIZE_1-1:0]           qp,
  output logic                        qp_valid,
  input  logic                        we,
  input  logic [SIZE_ADDRESS_PIX-1:0] write_addressp,
  input  logic signed [SIZE_1-1:0]    dp,
  input  logic                        STOP,
  output logic                        err,
  input  logic                        err_clr,
  output logic [15:0]                 rd_cnt,
  output logic [15:0]                 wr_cnt,
  output logic [15:0]                 last_wr_cnt,
  output logic                        pass_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SIZE_ADDRESS_PIX:0] DEPTH_EXT = (SIZE_ADDRESS_PIX + 1)'(DEPTH);
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic [SIZE_1-1:0] mem [DEPTH];

  logic             rd_legal;
  logic             wr_legal;
  logic             rd_ok;
  logic             wr_ok;
  logic             illegal;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             stop_q;
  logic             stop_rise;
  logic [15:0]      rd_cnt_upd;
  logic [15:0]      wr_cnt_upd;

  always_comb begin
    rd_legal   = {1'b0, read_addressp} < DEPTH_EXT;
    wr_legal   = {1'b0, write_addressp} < DEPTH_EXT;
    rd_ok      = re && rd_legal;
    wr_ok      = we && wr_legal;
    illegal    = (re && !rd_legal) || (we && !wr_legal);
    rd_idx     = read_addressp[IDX_W-1:0];
    wr_idx     = write_addressp[IDX_W-1:0];
    stop_rise  = STOP && !stop_q;
    rd_cnt_upd = (rd_ok && rd_cnt != CNT_MAX) ? rd_cnt + 16'd1 : rd_cnt;
    wr_cnt_upd = (wr_ok && wr_cnt != CNT_MAX) ? wr_cnt + 16'd1 : wr_cnt;
  end

  // RAM array has no reset; only the request is gated while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok) begin
      mem[wr_idx] <= dp;
    end
  end

  // Write-first bypass: mem[] still holds the old word at this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      qp       <= '0;
      qp_valid <= 1'b0;
    end else begin
      qp_valid <= re;
      if (re) begin
        if (!rd_legal) begin
          qp <= '0;
        end else if (wr_ok && (write_addressp == read_addressp)) begin
          qp <= dp;
        end else begin
          qp <= mem[rd_idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err         <= 1'b0;
      stop_q      <= 1'b0;
      pass_done   <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      last_wr_cnt <= '0;
    end else begin
      stop_q    <= STOP;
      pass_done <= stop_rise;
      if (illegal) begin
        err <= 1'b1;
      end else if (err_clr) begin
        err <= 1'b0;
      end
      if (stop_rise) begin
        last_wr_cnt <= wr_cnt_upd;
        rd_cnt      <= '0;
        wr_cnt      <= '0;
      end else begin
        rd_cnt <= rd_cnt_upd;
        wr_cnt <= wr_cnt_upd;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maxp_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_maxp_mem
// Purpose  : scoreboard bench for maxp_mem with directed vectors
// Revision : 1.0
// ============================================================================
module tb_maxp_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re;
  logic [12:0] read_addressp;
  logic [10:0] qp;
  logic        qp_valid;
  logic        we;
  logic [12:0] write_addressp;
  logic [10:0] dp;
  logic        STOP;
  logic        err;
  logic        err_clr;
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;
  logic [15:0] last_wr_cnt;
  logic        pass_done;

  int passed = 0;
  int total  = 0;
  logic [10:0] exp_q [$];

  always #5 clk = ~clk;

  maxp_mem #(.SIZE_1(11), .SIZE_ADDRESS_PIX(13), .DEPTH(4096)) dut (
    .clk(clk), .rst_n(rst_n),
    .re(re), .read_addressp(read_addressp), .qp(qp), .qp_valid(qp_valid),
    .we(we), .write_addressp(write_addressp), .dp(dp),
    .STOP(STOP), .err(err), .err_clr(err_clr),
    .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .last_wr_cnt(last_wr_cnt),
    .pass_done(pass_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) $display("FAIL %s: got %0h expected %0h", name, act, expv);
    else passed++;
  endtask

  // Monitor: every qp_valid cycle consumes one expected read result.
  always @(negedge clk) begin
    if (qp_valid !== 1'b0) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL qp_unexpected: got valid=%b qp=%0d expected no valid", qp_valid, qp);
      end else begin
        logic [10:0] e;
        e = exp_q.pop_front();
        if (qp_valid !== 1'b1 || qp !== e)
          $display("FAIL qp_data: got %0d expected %0d", qp, e);
        else passed++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic r, input logic [12:0] ra, input logic [10:0] expq,
                    input logic w, input logic [12:0] wa, input logic [10:0] d);
    re = r; read_addressp = ra;
    we = w; write_addressp = wa; dp = d;
    if (r) exp_q.push_back(expq);
    step();
    re = 1'b0; we = 1'b0;
  endtask

  int pulses;

  initial begin
    rst_n = 1'b0; re = 1'b0; we = 1'b0; read_addressp = '0; write_addressp = '0;
    dp = '0; STOP = 1'b0; err_clr = 1'b0;
    step(); step();
    chk("rst_qp", qp, 0);
    chk("rst_qp_valid", qp_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    chk("rst_last_wr_cnt", last_wr_cnt, 0);
    chk("rst_pass_done", pass_done, 0);
    rst_n = 1'b1;
    step();

    // write then read back-to-back
    op(0, 0, 0, 1, 100, 20);
    op(0, 0, 0, 1, 101, 40);
    op(1, 100, 20, 0, 0, 0);
    op(1, 101, 40, 0, 0, 0);
    step();
    chk("wr_rd_rd_cnt", rd_cnt, 2);
    chk("wr_rd_wr_cnt", wr_cnt, 2);
    chk("hold_qp", qp, 40);
    chk("hold_qp_valid", qp_valid, 0);

    // collision: write-first
    op(0, 0, 0, 1, 500, 15);
    op(1, 500, 75, 1, 500, 75);
    op(1, 500, 75, 0, 0, 0);
    op(0, 0, 0, 1, 0, 7);
    chk("coll_rd_cnt", rd_cnt, 4);
    chk("coll_wr_cnt", wr_cnt, 5);

    // out of range
    op(1, 5000, 0, 0, 0, 0);
    op(0, 0, 0, 1, 4096, 95);
    chk("oor_err", err, 1);
    chk("oor_rd_cnt", rd_cnt, 4);
    chk("oor_wr_cnt", wr_cnt, 5);
    op(1, 0, 7, 0, 0, 0);
    chk("oor_err_sticky", err, 1);
    err_clr = 1'b1;
    op(1, 4200, 0, 0, 0, 0);
    chk("err_set_wins", err, 1);
    op(0, 0, 0, 0, 0, 0);
    err_clr = 1'b0;
    chk("err_cleared", err, 0);
    chk("oor_rd_cnt2", rd_cnt, 5);

    // pass close with no access in the STOP cycle
    STOP = 1'b1;
    step();
    chk("passA_done", pass_done, 1);
    chk("passA_last", last_wr_cnt, 5);
    chk("passA_rd_cnt", rd_cnt, 0);
    chk("passA_wr_cnt", wr_cnt, 0);
    STOP = 1'b0;
    step();
    chk("passA_done_low", pass_done, 0);

    // pass close: third write lands in the STOP rising cycle, STOP held 4 cycles
    op(0, 0, 0, 1, 200, 1);
    op(0, 0, 0, 1, 201, 2);
    STOP = 1'b1;
    pulses = 0;
    op(0, 0, 0, 1, 202, 3);
    if (pass_done === 1'b1) pulses++;
    chk("passB_last", last_wr_cnt, 3);
    chk("passB_wr_cnt", wr_cnt, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      if (pass_done === 1'b1) pulses++;
    end
    chk("passB_pulses", pulses, 1);
    STOP = 1'b0;
    op(1, 202, 3, 0, 0, 0);
    chk("passB_rd_cnt", rd_cnt, 1);

    // reset mid-operation
    rst_n = 1'b0;
    op(1, 100, 0, 1, 100, 99);
    void'(exp_q.pop_back());
    chk("mid_rst_qp_valid", qp_valid, 0);
    chk("mid_rst_qp", qp, 0);
    chk("mid_rst_rd_cnt", rd_cnt, 0);
    chk("mid_rst_last", last_wr_cnt, 0);
    rst_n = 1'b1;
    op(1, 100, 20, 0, 0, 0);
    op(1, 101, 40, 0, 0, 0);
    op(1, 0, 7, 0, 0, 0);

    // saturation
    we = 1'b1; write_addressp = 300; dp = 11'd9;
    repeat (65540) @(posedge clk);
    #1;
    chk("sat_wr_cnt", wr_cnt, 16'hFFFF);
    STOP = 1'b1;
    step();
    we = 1'b0; STOP = 1'b0;
    chk("sat_last", last_wr_cnt, 16'hFFFF);
    op(1, 300, 9, 0, 0, 0);
    step();

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
